// File: rtl/axi_mem_slave_if.sv
// AXI4 bundle between a master (the cache) and the axi_mem_slave backing store.
interface axi_mem_slave_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                        S_AXI_AWVALID;
  logic                        S_AXI_AWREADY;
  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID;
  logic [1:0]                  S_AXI_AWBURST;
  logic [7:0]                  S_AXI_AWLEN;
  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                        S_AXI_WVALID;
  logic                        S_AXI_WREADY;
  logic                        S_AXI_WLAST;
  logic [1:0]                  S_AXI_BRESP;
  logic                        S_AXI_BVALID;
  logic                        S_AXI_BREADY;
  logic [AXI_ID_WIDTH-1:0]     S_AXI_BID;
  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                        S_AXI_ARVALID;
  logic                        S_AXI_ARREADY;
  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID;
  logic [1:0]                  S_AXI_ARBURST;
  logic [7:0]                  S_AXI_ARLEN;
  logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                  S_AXI_RRESP;
  logic                        S_AXI_RVALID;
  logic                        S_AXI_RREADY;
  logic [AXI_ID_WIDTH-1:0]     S_AXI_RID;
  logic                        S_AXI_RLAST;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWID, S_AXI_AWBURST, S_AXI_AWLEN,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARBURST, S_AXI_ARLEN,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, S_AXI_BID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RID, S_AXI_RLAST
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWID, S_AXI_AWBURST, S_AXI_AWLEN,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARBURST, S_AXI_ARLEN,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID, S_AXI_BID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RID, S_AXI_RLAST
  );
endinterface

// File: rtl/axi_mem_slave.sv
// Burst-capable AXI4 memory slave: independent write (AW/W/B) and read (AR/R) FSMs
// over a byte-enabled word array, with SLVERR on out-of-range beats and illegal bursts.
module axi_mem_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 1024,
  parameter int RD_LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst,
  axi_mem_slave_if.slave s_axi
);
  localparam int STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(STRB_W);
  localparam int IDX_W     = AXI_ADDR_WIDTH - OFF_W;
  localparam int MEM_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int LAT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [IDX_W:0] MEM_LIMIT = (IDX_W + 1)'(MEM_WORDS);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [1:0]       burst,
                                                input logic [7:0]       len);
    logic [IDX_W-1:0] mask;
    mask = IDX_W'(len);
    case (burst)
      2'b00:   next_idx = idx;
      2'b10:   next_idx = (idx & ~mask) | ((idx + IDX_W'(1)) & mask);
      default: next_idx = idx + IDX_W'(1);
    endcase
  endfunction

  function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
    bad_burst = (burst == 2'b11) ||
                ((burst == 2'b10) &&
                 !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    in_range = {1'b0, idx} < MEM_LIMIT;
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Byte offset bits are ignored because every beat is full width.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_state_nxt;

  logic [AXI_ID_WIDTH-1:0] w_id;
  logic [IDX_W-1:0]        w_idx;
  logic [7:0]              w_len, w_cnt;
  logic [1:0]              w_burst;
  logic                    w_err;
  logic                    aw_hs, w_hs, b_hs, w_last_beat;

  assign aw_hs       = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs        = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign b_hs        = s_axi.S_AXI_BVALID && s_axi.S_AXI_BREADY;
  assign w_last_beat = (w_cnt == w_len);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Readies are masked by rst so nothing handshakes while reset is held.
  always_comb begin
    s_axi.S_AXI_AWREADY = (w_state == W_IDLE) && !rst;
    s_axi.S_AXI_WREADY  = (w_state == W_DATA) && !rst;
    s_axi.S_AXI_BVALID  = (w_state == W_RESP) && !rst;
    s_axi.S_AXI_BID     = w_id;
    s_axi.S_AXI_BRESP   = w_err ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi.S_AXI_AWID;
      w_idx   <= s_axi.S_AXI_AWADDR[AXI_ADDR_WIDTH-1:OFF_W];
      w_len   <= s_axi.S_AXI_AWLEN;
      w_burst <= s_axi.S_AXI_AWBURST;
      w_cnt   <= '0;
      w_err   <= bad_burst(s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWLEN);
    end else if (w_hs) begin
      w_idx <= next_idx(w_idx, w_burst, w_len);
      w_cnt <= w_cnt + 8'd1;
      if (!in_range(w_idx) || (s_axi.S_AXI_WLAST != w_last_beat)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && in_range(w_idx)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.S_AXI_WSTRB[b])
          mem[w_idx[MEM_IDX_W-1:0]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  r_state_t r_state, r_state_nxt;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [IDX_W-1:0]          r_idx, ar_idx, load_idx;
  logic [7:0]                r_len, r_cnt;
  logic [1:0]                r_burst, r_resp;
  logic [LAT_W-1:0]          r_lat;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic                      ar_hs, r_hs, r_last, load, load_bad;

  assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign r_hs   = s_axi.S_AXI_RVALID && s_axi.S_AXI_RREADY;
  assign r_last = (r_cnt == r_len);
  assign ar_idx = s_axi.S_AXI_ARADDR[AXI_ADDR_WIDTH-1:OFF_W];

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_lat == '0) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.S_AXI_ARREADY = (r_state == R_IDLE) && !rst;
    s_axi.S_AXI_RVALID  = (r_state == R_DATA) && !rst;
    s_axi.S_AXI_RLAST   = (r_state == R_DATA) && r_last && !rst;
    s_axi.S_AXI_RID     = r_id;
    s_axi.S_AXI_RDATA   = r_data;
    s_axi.S_AXI_RRESP   = r_resp;
  end

  // The beat register is refilled one edge before it is shown, so it stays
  // stable under stalls and a same-cycle write only affects later beats.
  always_comb begin
    load     = 1'b0;
    load_idx = r_idx;
    load_bad = bad_burst(r_burst, r_len);
    case (r_state)
      R_IDLE: begin
        if (ar_hs && (RD_LATENCY == 0)) begin
          load     = 1'b1;
          load_idx = ar_idx;
          load_bad = bad_burst(s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARLEN);
        end
      end
      R_WAIT:  load = (r_lat == '0);
      R_DATA: begin
        if (r_hs && !r_last) begin
          load     = 1'b1;
          load_idx = next_idx(r_idx, r_burst, r_len);
        end
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_lat   <= '0;
      r_data  <= '0;
      r_resp  <= '0;
    end else begin
      if (ar_hs) begin
        r_id    <= s_axi.S_AXI_ARID;
        r_idx   <= ar_idx;
        r_len   <= s_axi.S_AXI_ARLEN;
        r_burst <= s_axi.S_AXI_ARBURST;
        r_cnt   <= '0;
        r_lat   <= (RD_LATENCY > 0) ? LAT_W'(RD_LATENCY - 1) : '0;
      end else if ((r_state == R_WAIT) && (r_lat != '0)) begin
        r_lat <= r_lat - LAT_W'(1);
      end
      if (r_hs && !r_last) begin
        r_idx <= load_idx;
        r_cnt <= r_cnt + 8'd1;
      end
      if (load) begin
        r_data <= in_range(load_idx) ? mem[load_idx[MEM_IDX_W-1:0]] : '0;
        r_resp <= (!in_range(load_idx) || load_bad) ? 2'b10 : 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed-burst bench for axi_mem_slave: stimulus tasks queue expected B/R responses,
// independent monitors pop and compare them whenever the DUT presents a response.
module tb_axi_mem_slave;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int MW  = 1024;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

  axi_mem_slave #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
    .MEM_WORDS(MW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axi(bus)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] wd [16];
  logic [7:0]    ws [16];
  logic [DW-1:0] ed [16];
  logic [1:0]    er [16];
  logic          early_last = 1'b0;
  logic          toggle_rr  = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.S_AXI_AWREADY;
      1:       return bus.S_AXI_WREADY;
      2:       return bus.S_AXI_ARREADY;
      default: return bus.S_AXI_RVALID;
    endcase
  endfunction

  task automatic wait_high(input string name, input int which, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!sig(which) && cycles < 64);
    if (!sig(which)) check_output({name, "_timeout"}, 64'(sig(which)), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.S_AXI_BVALID) begin
      if (bq.size() == 0) check_output("b_unexpected", 64'(bq.size()), 64'd1);
      else begin
        check_output("bid",   64'(bus.S_AXI_BID),   64'(bq[0].id));
        check_output("bresp", 64'(bus.S_AXI_BRESP), 64'(bq[0].resp));
        if (bus.S_AXI_BREADY) void'(bq.pop_front());
      end
    end
  end

  // A stalled beat is compared against the same queue head on every cycle, which checks stability.
  always @(negedge clk) begin
    if (!rst && bus.S_AXI_RVALID) begin
      if (rq.size() == 0) check_output("r_unexpected", 64'(rq.size()), 64'd1);
      else begin
        check_output("rdata", bus.S_AXI_RDATA,        rq[0].data);
        check_output("rresp", 64'(bus.S_AXI_RRESP),   64'(rq[0].resp));
        check_output("rlast", 64'(bus.S_AXI_RLAST),   64'(rq[0].last));
        check_output("rid",   64'(bus.S_AXI_RID),     64'(rq[0].id));
        if (bus.S_AXI_RREADY) void'(rq.pop_front());
      end
    end
  end

  task automatic apply_write(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                             input logic [1:0] burst, input logic [7:0] len,
                             input logic [1:0] exp_resp);
    int n;
    bq.push_back('{id: id, resp: exp_resp});
    @(posedge clk); #1;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWID    = id;
    bus.S_AXI_AWBURST = burst;
    bus.S_AXI_AWLEN   = len;
    bus.S_AXI_AWVALID = 1'b1;
    wait_high("awready", 0, n);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.S_AXI_WDATA  = wd[i];
      bus.S_AXI_WSTRB  = ws[i];
      bus.S_AXI_WLAST  = early_last ? (i == 0) : (i == int'(len));
      bus.S_AXI_WVALID = 1'b1;
      wait_high("wready", 1, n);
      if (i == 0) check_output("wready_lat", 64'(n), 64'd1);
      @(posedge clk); #1;
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    @(negedge clk);
    check_output("bvalid_lat", 64'(bus.S_AXI_BVALID), 64'd1);
    @(negedge clk);
    check_output("awready_after_b", 64'(bus.S_AXI_AWREADY), 64'd1);
    check_output("bvalid_drop",     64'(bus.S_AXI_BVALID),  64'd0);
  endtask

  task automatic apply_read(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                            input logic [1:0] burst, input logic [7:0] len);
    int n;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{data: ed[i], resp: er[i], last: (i == int'(len)), id: id});
    @(posedge clk); #1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARID    = id;
    bus.S_AXI_ARBURST = burst;
    bus.S_AXI_ARLEN   = len;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = !toggle_rr;
    wait_high("arready", 2, n);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    wait_high("rvalid", 3, n);
    check_output("rvalid_lat", 64'(n), 64'(LAT + 1));
    n = 0;
    while (!(bus.S_AXI_RVALID && bus.S_AXI_RREADY && bus.S_AXI_RLAST) && n < 200) begin
      @(posedge clk); #1;
      if (toggle_rr) bus.S_AXI_RREADY = !bus.S_AXI_RREADY;
      @(negedge clk);
      n++;
    end
    check_output("rlast_seen", 64'(bus.S_AXI_RVALID && bus.S_AXI_RREADY && bus.S_AXI_RLAST), 64'd1);
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    check_output("arready_after_r", 64'(bus.S_AXI_ARREADY), 64'd1);
    check_output("rvalid_drop",     64'(bus.S_AXI_RVALID),  64'd0);
  endtask

  task automatic reset_mid_read();
    int n;
    rq.push_back('{data: ed[0], resp: 2'b00, last: 1'b0, id: 4'd12});
    rq.push_back('{data: ed[1], resp: 2'b00, last: 1'b0, id: 4'd12});
    @(posedge clk); #1;
    bus.S_AXI_ARADDR  = 32'h100;
    bus.S_AXI_ARID    = 4'd12;
    bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_ARLEN   = 8'd7;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    wait_high("arready", 2, n);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    wait_high("rvalid", 3, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    check_output("rst_rvalid",  64'(bus.S_AXI_RVALID),  64'd0);
    check_output("rst_rlast",   64'(bus.S_AXI_RLAST),   64'd0);
    check_output("rst_rdata",   bus.S_AXI_RDATA,        64'd0);
    check_output("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd1);
    check_output("rst_rq_left", 64'(rq.size()),         64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWID = '0;
    bus.S_AXI_AWBURST = '0; bus.S_AXI_AWLEN = '0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARID = '0;
    bus.S_AXI_ARBURST = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wd[i] = '0; ws[i] = 8'hFF; ed[i] = '0; er[i] = 2'b00;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
    check_output("reset_wready",  64'(bus.S_AXI_WREADY),  64'd0);
    check_output("reset_bvalid",  64'(bus.S_AXI_BVALID),  64'd0);
    check_output("reset_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
    check_output("reset_rvalid",  64'(bus.S_AXI_RVALID),  64'd0);
    check_output("reset_rlast",   64'(bus.S_AXI_RLAST),   64'd0);
    check_output("reset_bresp",   64'(bus.S_AXI_BRESP),   64'd0);
    check_output("reset_rresp",   64'(bus.S_AXI_RRESP),   64'd0);
    check_output("reset_bid",     64'(bus.S_AXI_BID),     64'd0);
    check_output("reset_rid",     64'(bus.S_AXI_RID),     64'd0);
    check_output("reset_rdata",   bus.S_AXI_RDATA,        64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("post_reset_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
    check_output("post_reset_arready", 64'(bus.S_AXI_ARREADY), 64'd1);

    wd[0] = 64'h0123456789ABCDEF;
    apply_write(32'h0, 4'd3, 2'b01, 8'd0, 2'b00);
    ed[0] = 64'h0123456789ABCDEF;
    apply_read(32'h0, 4'd3, 2'b01, 8'd0);

    wd[0] = 64'hFFFFFFFFFFFFFFFF;
    apply_write(32'h8, 4'd1, 2'b01, 8'd0, 2'b00);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    apply_write(32'h8, 4'd2, 2'b01, 8'd0, 2'b00);
    ws[0] = 8'hFF;
    ed[0] = 64'hFFFFFFFF00000000;
    apply_read(32'h8, 4'd4, 2'b01, 8'd0);

    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'(i + 1);
      ed[i] = 64'(i + 1);
    end
    apply_write(32'h40, 4'd5, 2'b01, 8'd3, 2'b00);
    toggle_rr = 1'b1;
    apply_read(32'h40, 4'd5, 2'b01, 8'd3);
    toggle_rr = 1'b0;

    // WRAP from word 11 with len 3 covers words 11,8,9,10.
    wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC; wd[3] = 64'hD;
    apply_write(32'h58, 4'd6, 2'b10, 8'd3, 2'b00);
    ed[0] = 64'hB; ed[1] = 64'hC; ed[2] = 64'hD; ed[3] = 64'hA;
    apply_read(32'h40, 4'd7, 2'b01, 8'd3);
    ed[0] = 64'hA; ed[1] = 64'hB; ed[2] = 64'hC; ed[3] = 64'hD;
    apply_read(32'h58, 4'd8, 2'b10, 8'd3);

    wd[0] = 64'hDEADBEEFDEADBEEF;
    apply_write(32'h2000, 4'd9, 2'b01, 8'd0, 2'b10);
    ed[0] = 64'h0123456789ABCDEF;
    apply_read(32'h0, 4'd9, 2'b01, 8'd0);
    ed[0] = 64'h0; er[0] = 2'b10;
    apply_read(32'h2000, 4'd10, 2'b01, 8'd0);
    er[0] = 2'b00;

    wd[0] = 64'h55; wd[1] = 64'h66;
    early_last = 1'b1;
    apply_write(32'h100, 4'd11, 2'b01, 8'd1, 2'b10);
    early_last = 1'b0;

    wd[0] = 64'h77; wd[1] = 64'h88;
    apply_write(32'h180, 4'd12, 2'b00, 8'd1, 2'b00);
    ed[0] = 64'h88;
    apply_read(32'h180, 4'd12, 2'b01, 8'd0);

    wd[0] = 64'h1; wd[1] = 64'h2; wd[2] = 64'h3;
    apply_write(32'h1C0, 4'd14, 2'b10, 8'd2, 2'b10);
    ed[0] = 64'h0123456789ABCDEF; er[0] = 2'b10;
    apply_read(32'h0, 4'd13, 2'b11, 8'd0);
    er[0] = 2'b00;

    for (int i = 0; i < 8; i++) wd[i] = 64'(16 + i);
    apply_write(32'h100, 4'd15, 2'b01, 8'd7, 2'b00);
    ed[0] = 64'h10; ed[1] = 64'h11;
    reset_mid_read();
    ed[0] = 64'h11;
    apply_read(32'h108, 4'd1, 2'b01, 8'd0);

    repeat (4) @(negedge clk);
    check_output("bq_drained", 64'(bq.size()), 64'd0);
    check_output("rq_drained", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave
Parametrised AXI4 memory slave that terminates the cache's AXI master port (AW/W/B/AR/R), replacing fixed single-beat bench stimulus with a synthesizable, burst-capable backing store. It supports FIXED/INCR/WRAP bursts, WSTRB byte enables, per-transaction ID echo, configurable read latency and SLVERR signalling. It serves as the memory model in cache simulations and as on-chip scratch memory.
## Interface
- AXI_ADDR_WIDTH, 32, byte address width
- AXI_DATA_WIDTH, 64, beat width (multiple of 8, power of two); all beats are full width, size is not decoded
- AXI_ID_WIDTH, 4, transaction ID width
- MEM_WORDS, 1024, depth in AXI_DATA_WIDTH words; word index = addr >> log2(AXI_DATA_WIDTH/8)
- RD_LATENCY, 2, idle cycles between AR handshake and first R beat (0 allowed)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write start address (low byte-offset bits ignored)
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_AWID  in  AXI_ID_WIDTH  write ID
- S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- S_AXI_AWLEN  in  8  beats minus one
- S_AXI_WDATA  in  AXI_DATA_WIDTH  write data
- S_AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_WLAST  in  1  last write beat
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_BID  out  AXI_ID_WIDTH  echoed AWID
- S_AXI_ARADDR  in  AXI_ADDR_WIDTH  read start address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_ARID  in  AXI_ID_WIDTH  read ID
- S_AXI_ARBURST  in  2  as AWBURST
- S_AXI_ARLEN  in  8  beats minus one
- S_AXI_RDATA  out  AXI_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  per-beat response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- S_AXI_RID  out  AXI_ID_WIDTH  echoed ARID
- S_AXI_RLAST  out  1  last read beat
## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. AWREADY=1 only in W_IDLE; AW handshake latches id/addr/len/burst, clears beat count and error flag. WREADY=1 only in W_DATA; each W handshake writes bytes with WSTRB=1 to current word, advances address, increments count. Beat with count==len -> W_RESP. BVALID=1 in W_RESP, held with BID/BRESP stable until BREADY -> W_IDLE.
- Write error flag set by: any out-of-range beat (word index >= MEM_WORDS; write suppressed), WLAST value != (count==len) on any beat, burst 11, WRAP with len not in {1,3,7,15}. Flag -> BRESP=10, else 00. Burst length always taken from AWLEN, never WLAST.
- Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE. ARREADY=1 only in R_IDLE; handshake latches fields, loads latency counter; R_WAIT skipped when RD_LATENCY=0. In R_DATA: RVALID=1, RDATA=mem[current word] (0 if out of range), RID latched, RLAST=(count==len), RRESP=10 for out-of-range beat or illegal burst/len, else 00. Advance on RVALID&&RREADY; RLAST handshake -> R_IDLE.
- Address advance (word index i, mask m=len): FIXED i unchanged; INCR i+1 (wraps modulo 2^(AXI_ADDR_WIDTH-log2 bytes)); WRAP (i & ~m) | ((i+1) & m); reserved 11 advances as INCR.
- Channels fully independent; one outstanding transaction per direction. Same-cycle write and read beat to same word: read beat returns pre-write data.
- Memory contents not reset and not initialised.
## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP, BID, RID, RDATA = 0; FSMs to idle. AWREADY/ARREADY = 1 first cycle after rst deasserts.
- rst mid-burst: transaction abandoned, already-written beats retained, outputs at reset values next cycle.
- AW handshake cycle T -> WREADY=1 at T+1. Last W beat at T -> BVALID at T+1. B handshake at T -> AWREADY at T+1.
- AR handshake at T -> first RVALID at T+1+RD_LATENCY. One beat/cycle with RREADY held; outputs stable while RVALID && !RREADY. RLAST handshake at T -> ARREADY at T+1.
## Test plan
- Write len0 addr 0x0 id 3 data 0x0123456789ABCDEF strb 0xFF -> BVALID one cycle after WLAST, BID 3, BRESP 00; read back -> RDATA 0x0123456789ABCDEF, RLAST=1, RID matches, first RVALID RD_LATENCY+1 cycles after AR.
- Write 0xFFFFFFFFFFFFFFFF to 0x8, then 0x0 strb 0x0F -> readback 0xFFFFFFFF00000000.
- INCR len3 at 0x40, data 1..4, id 5; read with RREADY toggling every cycle -> beats 1,2,3,4 stable under stall, RLAST only on 4th, RID 5.
- WRAP len3 starting 0x58 (word 11) writing A,B,C,D -> words 11,8,9,10 = A,B,C,D; WRAP read from 0x58 returns A,B,C,D.
- Write to word MEM_WORDS -> BRESP 10, no memory change; read there -> RDATA 0, RRESP 10; len1 write with WLAST on beat 0 -> BRESP 10.
- Assert rst during beat 2 of INCR len7 read -> RVALID 0 next cycle, ARREADY 1 cycle after rst drops, new read completes OKAY.
